// File: rtl/sqrt_square_reconstruct_pkg.sv
// Shared definitions for the sqrt reconstruct block: default widths
// and the FSM state encoding also used by the sqrt block and its bench.
package sqrt_square_reconstruct_pkg;

  localparam int ROOT_W_DEF = 5;
  localparam int X_W_DEF    = 8;
  localparam int PROD_W_DEF = 2 * ROOT_W_DEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_ADD  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  // Counter width for a ROOT_W-cycle loop, never narrower than one bit
  function automatic int cnt_width(input int root_w);
    return (root_w > 1) ? $clog2(root_w) : 1;
  endfunction

endpackage

// File: rtl/sqrt_square_reconstruct_if.sv
// Request/result bundle between a requester and the reconstruct block.
interface sqrt_square_reconstruct_if #(
  parameter int ROOT_W = 5,
  parameter int PROD_W = 2 * ROOT_W
);

  logic              START;
  logic [ROOT_W-1:0] ROOT_IN;
  logic [ROOT_W:0]   REM_IN;
  logic              BUSY;
  logic              DONE;
  logic [PROD_W-1:0] X_OUT;
  logic              OVF;
  logic              REM_ERR;

  modport master (
    output START, ROOT_IN, REM_IN,
    input  BUSY, DONE, X_OUT, OVF, REM_ERR
  );

  modport slave (
    input  START, ROOT_IN, REM_IN,
    output BUSY, DONE, X_OUT, OVF, REM_ERR
  );

endinterface

// File: rtl/sqrt_square_reconstruct_shift_add_step.sv
// One iteration of the shift-add multiply: conditionally add the
// current multiplicand, then move both operands by one bit position.
module sqrt_shift_add_step #(
  parameter int ROOT_W = 5,
  parameter int PROD_W = 2 * ROOT_W
) (
  input  logic [PROD_W-1:0] acc_in,
  input  logic [PROD_W-1:0] mcand_in,
  input  logic [ROOT_W-1:0] mplier_in,
  output logic [PROD_W-1:0] acc_out,
  output logic [PROD_W-1:0] mcand_out,
  output logic [ROOT_W-1:0] mplier_out
);

  // Partial product add, gated by the current multiplier LSB
  always_comb begin
    acc_out    = mplier_in[0] ? (acc_in + mcand_in) : acc_in;
    mcand_out  = mcand_in << 1;
    mplier_out = mplier_in >> 1;
  end

endmodule

// File: rtl/sqrt_square_reconstruct.sv
// Rebuilds X = ROOT*ROOT + REM with a one-bit-per-cycle shift-add
// multiply, flagging results outside the radicand domain and illegal
// remainders.
module sqrt_square_reconstruct
  import sqrt_square_reconstruct_pkg::*;
#(
  parameter int ROOT_W = ROOT_W_DEF,
  parameter int X_W    = X_W_DEF,
  parameter int PROD_W = 2 * ROOT_W
) (
  input  logic                        CLK,
  input  logic                        RST,
  sqrt_square_reconstruct_if.slave    bus
);

  localparam int CNT_W = cnt_width(ROOT_W);

  state_t            state_q;
  logic [PROD_W-1:0] acc_q;
  logic [PROD_W-1:0] mcand_q;
  logic [ROOT_W-1:0] mplier_q;
  logic [ROOT_W-1:0] root_q;
  logic [ROOT_W:0]   rem_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              carry_q;
  logic              rem_err_q;

  logic              busy_q;
  logic              done_q;
  logic [PROD_W-1:0] x_out_q;
  logic              ovf_q;
  logic              rem_err_out_q;

  logic [PROD_W-1:0] step_acc;
  logic [PROD_W-1:0] step_mcand;
  logic [ROOT_W-1:0] step_mplier;
  logic [PROD_W:0]   add_sum;
  logic              rem_illegal;

  sqrt_shift_add_step #(
    .ROOT_W (ROOT_W),
    .PROD_W (PROD_W)
  ) u_step (
    .acc_in     (acc_q),
    .mcand_in   (mcand_q),
    .mplier_in  (mplier_q),
    .acc_out    (step_acc),
    .mcand_out  (step_mcand),
    .mplier_out (step_mplier)
  );

  // Remainder add keeps its carry so a wrapped result still reports OVF
  always_comb begin
    add_sum     = {1'b0, acc_q} + (PROD_W + 1)'(rem_q);
    rem_illegal = ({1'b0, rem_q} > {1'b0, root_q, 1'b0});
  end

  // Control FSM with operand/accumulator registers and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      acc_q         <= '0;
      mcand_q       <= '0;
      mplier_q      <= '0;
      root_q        <= '0;
      rem_q         <= '0;
      cnt_q         <= '0;
      carry_q       <= 1'b0;
      rem_err_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      x_out_q       <= '0;
      ovf_q         <= 1'b0;
      rem_err_out_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // A request landing on the DONE cycle is dropped, not queued
          if (bus.START && !done_q) begin
            mcand_q  <= PROD_W'(bus.ROOT_IN);
            mplier_q <= bus.ROOT_IN;
            root_q   <= bus.ROOT_IN;
            rem_q    <= bus.REM_IN;
            acc_q    <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= CNT_W'(ROOT_W - 1);
            busy_q   <= 1'b1;
            state_q  <= ST_MULT;
          end
        end
        ST_MULT: begin
          acc_q    <= step_acc;
          mcand_q  <= step_mcand;
          mplier_q <= step_mplier;
          if (cnt_q == '0) begin
            state_q <= ST_ADD;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_ADD: begin
          acc_q     <= add_sum[PROD_W-1:0];
          carry_q   <= add_sum[PROD_W];
          rem_err_q <= rem_illegal;
          state_q   <= ST_FIN;
        end
        ST_FIN: begin
          x_out_q       <= acc_q;
          ovf_q         <= (|acc_q[PROD_W-1:X_W]) | carry_q;
          rem_err_out_q <= rem_err_q;
          done_q        <= 1'b1;
          busy_q        <= 1'b0;
          state_q       <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.BUSY    = busy_q;
  assign bus.DONE    = done_q;
  assign bus.X_OUT   = x_out_q;
  assign bus.OVF     = ovf_q;
  assign bus.REM_ERR = rem_err_out_q;

endmodule
